// File: rtl/dpi_flow_ctx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dpi_flow_ctx_sched                                              |
// | Brief    : Per-flow DFA context scheduler feeding a regex DFA stage.       |
// |            Optional feature macro: DPI_FLOW_RESUME_EN (per-flow table).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dpi_flow_ctx_sched #(
    parameter int FLOW_W  = 4,
    parameter int STATE_W = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [7:0]         in_byte,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [FLOW_W-1:0]  in_flow,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state,
    output logic               dfa_state_vld,
    input  logic [STATE_W-1:0] dfa_state_cur,
    input  logic               dfa_accept,
    output logic               res_vld,
    output logic [FLOW_W-1:0]  res_flow,
    output logic               res_hit,
    output logic               res_err,
    output logic [15:0]        drop_cnt
);
    localparam logic [2:0] c_st_init   = 3'd0;
    localparam logic [2:0] c_st_idle   = 3'd1;
    localparam logic [2:0] c_st_load   = 3'd2;
    localparam logic [2:0] c_st_stream = 3'd3;
    localparam logic [2:0] c_st_save   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [FLOW_W-1:0]  r_cur_flow;
    logic               r_hit;
    logic               r_err;
    logic               r_first;
    logic [15:0]        r_drop_cnt;
    logic               w_premature;
    logic               w_accept;
    logic               w_idx_last;
    logic [STATE_W-1:0] w_load_state;

    // A sop arriving after the packet's own sop beat closes the packet without consuming it
    assign w_premature = (r_state == c_st_stream) && in_vld && in_sop && !r_first;
    assign w_accept    = in_vld && in_rdy;
    assign drop_cnt    = r_drop_cnt;

`ifdef DPI_FLOW_RESUME_EN
    localparam logic [2:0] c_st_reset = c_st_init;

    logic [STATE_W-1:0] r_table [2**FLOW_W];
    logic [FLOW_W-1:0]  r_idx;

    assign w_idx_last   = &r_idx;
    assign w_load_state = r_table[r_cur_flow];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (r_state == c_st_init) begin
            r_idx <= r_idx + FLOW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_st_init) begin
                r_table[r_idx] <= '0;
            end else if (r_state == c_st_save) begin
                r_table[r_cur_flow] <= dfa_state_cur;
            end
        end
    end
`else
    localparam logic [2:0] c_st_reset = c_st_idle;

    logic w_unused_state;

    assign w_idx_last     = 1'b1;
    assign w_load_state   = '0;
    assign w_unused_state = ^dfa_state_cur;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_reset;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_init:   if (w_idx_last) w_next = c_st_idle;
            c_st_idle:   if (in_vld && in_sop) w_next = c_st_load;
            c_st_load:   w_next = c_st_stream;
            c_st_stream: if (w_premature || (w_accept && in_eop)) w_next = c_st_save;
            c_st_save:   w_next = c_st_idle;
            default:     w_next = c_st_reset;
        endcase
    end

    always_comb begin
        in_rdy        = 1'b0;
        dfa_char      = '0;
        dfa_char_vld  = 1'b0;
        dfa_state     = '0;
        dfa_state_vld = 1'b0;
        res_vld       = 1'b0;
        res_flow      = '0;
        res_hit       = 1'b0;
        res_err       = 1'b0;
        case (r_state)
            c_st_idle: in_rdy = in_vld && !in_sop;
            c_st_load: begin
                dfa_state     = w_load_state;
                dfa_state_vld = 1'b1;
            end
            c_st_stream: begin
                in_rdy       = !w_premature;
                dfa_char     = in_byte;
                dfa_char_vld = in_vld && !w_premature;
            end
            c_st_save: begin
                res_vld  = 1'b1;
                res_flow = r_cur_flow;
                res_hit  = r_hit;
                res_err  = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_flow <= '0;
            r_hit      <= 1'b0;
            r_err      <= 1'b0;
            r_first    <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (r_state == c_st_idle && in_vld) begin
                if (in_sop) begin
                    r_cur_flow <= in_flow;
                    r_hit      <= 1'b0;
                end else if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
            if (r_state == c_st_load) begin
                r_first <= 1'b1;
            end
            if (r_state == c_st_stream && w_accept) begin
                r_first <= 1'b0;
                r_hit   <= r_hit | dfa_accept;
            end
            if (w_premature) begin
                r_err <= 1'b1;
            end
            if (r_state == c_st_save) begin
                r_err <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dpi_flow_ctx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dpi_flow_ctx_sched                                           |
// | Brief    : Scoreboard bench with a substring-search reference model.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dpi_flow_ctx_sched;
    localparam int FLOW_W  = 4;
    localparam int STATE_W = 11;
    localparam int NFLOW   = 2**FLOW_W;
`ifdef DPI_FLOW_RESUME_EN
    localparam bit RESUME = 1'b1;
`else
    localparam bit RESUME = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_vld, in_rdy, in_sop, in_eop;
    logic [7:0]         in_byte;
    logic [FLOW_W-1:0]  in_flow;
    logic [7:0]         dfa_char;
    logic               dfa_char_vld, dfa_state_vld, dfa_accept;
    logic [STATE_W-1:0] dfa_state, dfa_state_cur;
    logic               res_vld, res_hit, res_err;
    logic [FLOW_W-1:0]  res_flow;
    logic [15:0]        drop_cnt;

    always #5 clk = ~clk;

    dpi_flow_ctx_sched #(.FLOW_W(FLOW_W), .STATE_W(STATE_W)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_byte(in_byte),
        .in_sop(in_sop), .in_eop(in_eop), .in_flow(in_flow), .dfa_char(dfa_char),
        .dfa_char_vld(dfa_char_vld), .dfa_state(dfa_state), .dfa_state_vld(dfa_state_vld),
        .dfa_state_cur(dfa_state_cur), .dfa_accept(dfa_accept), .res_vld(res_vld),
        .res_flow(res_flow), .res_hit(res_hit), .res_err(res_err), .drop_cnt(drop_cnt)
    );

    // Stand-in DFA: state = length of matched prefix of the pattern ('r' occurs only at its start)
    logic [7:0]         pat [12];
    logic [STATE_W-1:0] dfa_st = '0;

    function automatic logic [STATE_W-1:0] dfa_step(input logic [STATE_W-1:0] s, input logic [7:0] c);
        if (s < 11'd12 && c == pat[int'(s)]) return s + 11'd1;
        return (c == pat[0]) ? 11'd1 : 11'd0;
    endfunction

    always @(posedge clk) begin
        if (dfa_state_vld) dfa_st <= dfa_state;
        else if (dfa_char_vld) dfa_st <= dfa_step(dfa_st, dfa_char);
    end
    assign dfa_state_cur = dfa_st;
    assign dfa_accept    = dfa_char_vld && (dfa_step(dfa_st, dfa_char) == 11'd12);

    typedef struct packed {
        logic [FLOW_W-1:0] flow;
        logic              hit;
        logic              err;
    } res_t;

    res_t        exp_q[$];
    logic [7:0]  hist [NFLOW][$];
    int          prog [NFLOW];
    int          vectors = 0;
    int          miscompares = 0;
    int          n_chars = 0;
    int          exp_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every result beat pops the scoreboard
    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            if (dfa_char_vld) n_chars++;
            if (dfa_char_vld && dfa_state_vld) begin
                vectors++;
                miscompares++;
                $display("FAIL vld_overlap: got char_vld=1 state_vld=1, expected not both");
            end
            if (res_vld) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL res_unexpected: got res flow=%0d, expected no result", res_flow);
                end else begin
                    e = exp_q.pop_front();
                    check("res{flow,hit,err}", 32'({res_flow, res_hit, res_err}), 32'(e));
                end
            end
        end
    end

    // Reference: hit iff the pattern ends inside this packet within the flow's byte history
    task automatic model_pkt(input int f, input logic [7:0] data[$], input bit err);
        logic [7:0] s[$];
        bit         hit;
        bit         m;
        int         base;
        res_t       e;
        s = {};
        if (RESUME) s = hist[f];
        base = s.size();
        foreach (data[i]) s.push_back(data[i]);
        hit = 1'b0;
        for (int k = base; k < s.size(); k++) begin
            if (k >= 11) begin
                m = 1'b1;
                for (int j = 0; j < 12; j++) if (s[k-11+j] != pat[j]) m = 1'b0;
                if (m) hit = 1'b1;
            end
        end
        while (s.size() > 11) void'(s.pop_front());
        hist[f] = s;
        e.flow = f[FLOW_W-1:0];
        e.hit  = hit;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic put(input logic [7:0] b, input logic sop, input logic eop, input int f,
                       input bit chk_char, output int lat);
        logic r, cv;
        logic [7:0] cc;
        in_vld = 1'b1; in_byte = b; in_sop = sop; in_eop = eop; in_flow = f[FLOW_W-1:0];
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            r = in_rdy; cv = dfa_char_vld; cc = dfa_char;
            @(posedge clk);
            #1;
            if (r) begin
                lat = i;
                break;
            end
        end
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout: got no in_rdy in 64 cycles, expected acceptance");
        end else if (chk_char) begin
            check("dfa_char", 32'({cv, cc}), 32'({1'b1, b}));
        end
    endtask

    task automatic send_pkt(input int f, input logic [7:0] data[$], input bit noeop,
                            input bit do_model, output int lat0);
        int lat;
        lat0 = -1;
        for (int i = 0; i < data.size(); i++) begin
            put(data[i], i == 0, !noeop && (i == data.size() - 1), f, 1'b1, lat);
            if (i == 0) lat0 = lat;
        end
        if (do_model) model_pkt(f, data, noeop);
    endtask

    task automatic str2q(input string s, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic gen(input int f, input int len, output logic [7:0] d[$]);
        d = {};
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) d.push_back(8'($urandom_range(65, 90)));
            else begin
                d.push_back(pat[prog[f]]);
                prog[f] = (prog[f] + 1) % 12;
            end
        end
    endtask

    task automatic clear_model;
        for (int i = 0; i < NFLOW; i++) begin
            hist[i].delete();
            prog[i] = 0;
        end
        exp_drop = 0;
    endtask

    initial begin
        string      P;
        logic [7:0] d[$];
        int         lat0, lat, nchar0, f, len;
        bit         noeop;

        P = "rfb 003.008\n";
        for (int i = 0; i < 12; i++) pat[i] = P[i];
        clear_model();
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_byte = '0; in_flow = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({in_rdy, dfa_char_vld, dfa_state_vld, res_vld, dfa_char, drop_cnt}), 32'd0);
        rst = 1'b0;

        // First packet straight out of reset: startup latency then a full in-packet match
        str2q("rfb 003.008\n", d);
        send_pkt(3, d, 1'b0, 1'b1, lat0);
        check("startup_latency", 32'(lat0), RESUME ? 32'(NFLOW + 2) : 32'd2);

        str2q("rfb 00", d);     send_pkt(5, d, 1'b0, 1'b1, lat0);
        str2q("xyz", d);        send_pkt(7, d, 1'b0, 1'b1, lat0);
        str2q("3.008\n", d);    send_pkt(5, d, 1'b0, 1'b1, lat0);

        // Drops while idle
        repeat (4) @(posedge clk);
        #1;
        nchar0 = n_chars;
        for (int i = 0; i < 2; i++) begin
            put(8'hEE, 1'b0, 1'b0, 0, 1'b0, lat);
            exp_drop++;
            check("drop_latency", 32'(lat), 32'd0);
        end
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        check("drop_no_dfa", 32'(n_chars), 32'(nchar0));

        // Premature sop: flow 2 closes with err, flow 9 sop held then processed
        str2q("abc", d);        send_pkt(2, d, 1'b1, 1'b1, lat0);
        str2q("rfb", d);        send_pkt(9, d, 1'b0, 1'b1, lat0);
        check("held_sop_latency", 32'(lat0), 32'd4);

        // Reset mid-stream after flow 5 has a saved partial match
        str2q("rfb 00", d);     send_pkt(5, d, 1'b0, 1'b1, lat0);
        str2q("rfb 0", d);      send_pkt(6, d, 1'b1, 1'b0, lat0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pending_before_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        clear_model();
        rst = 1'b0;
        check("drop_cnt_after_reset", 32'(drop_cnt), 32'd0);
        str2q("3.008\n", d);    send_pkt(5, d, 1'b0, 1'b1, lat0);
        check("restart_latency", 32'(lat0), RESUME ? 32'(NFLOW + 2) : 32'd2);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            f = $urandom_range(0, NFLOW - 1);
            len = $urandom_range(1, 8);
            noeop = (n != 39) && ($urandom_range(0, 9) == 0);
            gen(f, len, d);
            send_pkt(f, d, noeop, 1'b1, lat0);
            if (!noeop) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                if ($urandom_range(0, 6) == 0) begin
                    put(8'($urandom), 1'b0, 1'b0, 0, 1'b0, lat);
                    exp_drop++;
                end
            end
        end

        repeat (10) @(posedge clk);
        #1;
        check("results_outstanding", 32'(exp_q.size()), 32'd0);
        check("drop_cnt_final", 32'(drop_cnt), 32'(exp_drop));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
